// File: rtl/cpu_defs.sv
// Shared definitions for the single-issue CPU front end.
//   WORD     : datapath / address width in bits
//   PC_STEP  : byte increment between sequential instructions
//   RESET_PC : default program counter value after reset
//   NOP_INST : instruction word used for pipeline bubbles
package cpu_defs;
  localparam int              WORD     = 32;
  localparam logic [WORD-1:0] PC_STEP  = 32'd4;
  localparam logic [WORD-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [WORD-1:0] NOP_INST = 32'h0000_0000;
endpackage

// File: rtl/pc_reg.sv
// Program counter register with next-PC selection.
//   clk, rst  : clock, asynchronous active-high reset (loads RESET_PC)
//   stall     : hold pc
//   redirect  : load target (takes priority over stall)
//   target    : word-aligned redirect address
//   pc        : current fetch PC
module pc_reg
  import cpu_defs::*;
#(
  parameter logic [WORD-1:0] RESET_PC = cpu_defs::RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [WORD-1:0] target,
  output logic [WORD-1:0] pc
);

  logic [WORD-1:0] pc_nxt;

  always_comb begin
    pc_nxt = pc;
    if (redirect) begin
      pc_nxt = target;
    end else if (!stall) begin
      // Natural 32-bit wrap: 32'hFFFF_FFFC + 4 -> 0
      pc_nxt = pc + PC_STEP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_nxt;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives the combinational INST_ROM address from
// the PC, and captures the returned word plus its PC into the IF/ID register.
//   clk, rst   : clock, asynchronous active-high reset
//   stall      : hold PC, IF/ID and fetch_err
//   redirect   : taken branch/jump, load br_target and insert a bubble
//   br_target  : redirect byte address (low two bits dropped, flagged if set)
//   rom_addr   : INST_ROM address (equals pc)
//   rom_inst   : INST_ROM data for rom_addr, same cycle
//   pc         : current fetch PC
//   id_inst, id_pc, id_pc4, id_valid : IF/ID register contents
//   fetch_err  : sticky misaligned-target / out-of-range-fetch flag
module if_stage
  import cpu_defs::*;
#(
  parameter logic [WORD-1:0] RESET_PC  = cpu_defs::RESET_PC,
  parameter int              ROM_BYTES = 256,
  parameter logic [WORD-1:0] NOP_INST  = cpu_defs::NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [WORD-1:0] br_target,
  output logic [WORD-1:0] rom_addr,
  input  logic [WORD-1:0] rom_inst,
  output logic [WORD-1:0] pc,
  output logic [WORD-1:0] id_inst,
  output logic [WORD-1:0] id_pc,
  output logic [WORD-1:0] id_pc4,
  output logic            id_valid,
  output logic            fetch_err
);

  localparam logic [WORD-1:0] ROM_LIMIT = WORD'(ROM_BYTES);

  logic [WORD-1:0] target_aligned;
  logic            target_misaligned;
  logic            fetch_in_range;

  assign target_aligned    = {br_target[WORD-1:2], 2'b00};
  assign target_misaligned = |br_target[1:0];
  assign fetch_in_range    = (pc < ROM_LIMIT);
  assign rom_addr          = pc;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .redirect (redirect),
    .target   (target_aligned),
    .pc       (pc)
  );

  // ---- IF -> ID boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_inst   <= NOP_INST;
      id_pc     <= '0;
      id_pc4    <= PC_STEP;
      id_valid  <= 1'b0;
      fetch_err <= 1'b0;
    end else if (redirect) begin
      // Bubble; id_pc/id_pc4 keep their last values
      id_inst  <= NOP_INST;
      id_valid <= 1'b0;
      if (target_misaligned) begin
        fetch_err <= 1'b1;
      end
    end else if (!stall) begin
      id_pc  <= pc;
      id_pc4 <= pc + PC_STEP;
      if (fetch_in_range) begin
        id_inst  <= rom_inst;
        id_valid <= 1'b1;
      end else begin
        // ROM data beyond its size is meaningless; squash it
        id_inst   <= NOP_INST;
        id_valid  <= 1'b0;
        fetch_err <= 1'b1;
      end
    end
  end

endmodule
